// File: rtl/puck_physics_ctl.sv
// Air-hockey puck engine: mallet contact, friction, wall reflection, goal detection and score.
// One physics step per frame tick; goal pulses and score feed the HUD / game FSM.
module puck_physics_ctl #(
  parameter int RADIUS_BALL    = 10,
  parameter int PLAYERS_RADIUS = 20,
  parameter int X_MIN          = 32,
  parameter int X_MAX          = 991,
  parameter int Y_MIN          = 32,
  parameter int Y_MAX          = 735,
  parameter int GOAL_Y_MIN     = 300,
  parameter int GOAL_Y_MAX     = 468,
  parameter int START_X        = 487,
  parameter int START_Y        = 362,
  parameter int HIT_SPEED      = 6,
  parameter int VMAX           = 15,
  parameter int FRICTION_TICKS = 8,
  parameter int GOAL_HOLD      = 120
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        tick,
  input  logic        pause,
  input  logic [11:0] xpos_player_1,
  input  logic [11:0] ypos_player_1,
  input  logic [11:0] xpos_player_2,
  input  logic [11:0] ypos_player_2,
  output logic [11:0] xpos_ball,
  output logic [11:0] ypos_ball,
  output logic        goal_p1,
  output logic        goal_p2,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        in_play
);

  localparam int FW = $clog2(FRICTION_TICKS);
  localparam int HW = $clog2(GOAL_HOLD);

  // Wall tests are done on the puck centre, so the radius is folded into the limits.
  localparam logic signed [13:0] L_X_LO   = 14'(X_MIN + RADIUS_BALL);
  localparam logic signed [13:0] L_X_HI   = 14'(X_MAX - RADIUS_BALL);
  localparam logic signed [13:0] L_Y_LO   = 14'(Y_MIN + RADIUS_BALL);
  localparam logic signed [13:0] L_Y_HI   = 14'(Y_MAX - RADIUS_BALL);
  localparam logic [11:0]        L_X_LO_P = 12'(X_MIN + RADIUS_BALL);
  localparam logic [11:0]        L_X_HI_P = 12'(X_MAX - RADIUS_BALL);
  localparam logic [11:0]        L_Y_LO_P = 12'(Y_MIN + RADIUS_BALL);
  localparam logic [11:0]        L_Y_HI_P = 12'(Y_MAX - RADIUS_BALL);
  localparam logic [11:0]        L_GY_LO  = 12'(GOAL_Y_MIN);
  localparam logic [11:0]        L_GY_HI  = 12'(GOAL_Y_MAX);
  localparam logic [11:0]        L_START_X = 12'(START_X);
  localparam logic [11:0]        L_START_Y = 12'(START_Y);
  localparam logic signed [27:0] L_HIT_D2 = 28'((RADIUS_BALL + PLAYERS_RADIUS) * (RADIUS_BALL + PLAYERS_RADIUS));
  localparam logic signed [4:0]  L_HS     = 5'(HIT_SPEED);
  localparam logic signed [5:0]  L_VMAX6  = 6'(VMAX);
  localparam logic [FW-1:0]      L_FRIC_LAST = FW'(FRICTION_TICKS - 1);
  localparam logic [HW-1:0]      L_HOLD_LAST = HW'(GOAL_HOLD - 1);

  typedef enum logic [0:0] {S_PLAY = 1'b0, S_GOAL = 1'b1} state_t;

  typedef struct packed {
    logic              hit;
    logic signed [4:0] vx;
    logic signed [4:0] vy;
  } hit_t;

  function automatic logic signed [4:0] toward_zero(input logic signed [4:0] v);
    if (v > 5'sd0)      return v - 5'sd1;
    else if (v < 5'sd0) return v + 5'sd1;
    else                return v;
  endfunction

  function automatic logic signed [4:0] clamp_neg(input logic signed [4:0] v);
    logic signed [5:0] n;
    n = 6'sd0 - 6'(v);
    if (n > L_VMAX6)       return 5'(L_VMAX6);
    else if (n < -L_VMAX6) return 5'(-L_VMAX6);
    else                   return 5'(n);
  endfunction

  function automatic logic signed [4:0] dir(input logic signed [13:0] d);
    if (d > 14'sd0)      return L_HS;
    else if (d < 14'sd0) return -L_HS;
    else                 return 5'sd0;
  endfunction

  // A near-diagonal hit (neither axis more than twice the other) drives both components.
  function automatic hit_t contact(input logic [11:0] bx, input logic [11:0] by,
                                   input logic [11:0] px, input logic [11:0] py,
                                   input logic signed [4:0] vx_centre);
    logic signed [13:0] dx, dy, adx, ady;
    logic signed [27:0] d2;
    hit_t h;
    dx    = $signed({2'b00, bx}) - $signed({2'b00, px});
    dy    = $signed({2'b00, by}) - $signed({2'b00, py});
    adx   = (dx < 14'sd0) ? -dx : dx;
    ady   = (dy < 14'sd0) ? -dy : dy;
    d2    = 28'(dx) * 28'(dx) + 28'(dy) * 28'(dy);
    h.hit = (d2 <= L_HIT_D2);
    if ((dx == 14'sd0) && (dy == 14'sd0)) begin
      h.vx = vx_centre;
      h.vy = 5'sd0;
    end else begin
      h.vx = ((15'(adx) <<< 1) >= 15'(ady)) ? dir(dx) : 5'sd0;
      h.vy = ((15'(ady) <<< 1) >= 15'(adx)) ? dir(dy) : 5'sd0;
    end
    return h;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [11:0]       r_x, r_y;
  logic signed [4:0] r_vx, r_vy;
  logic [FW-1:0]     r_fric;
  logic [HW-1:0]     r_hold;
  logic [3:0]        r_score_1, r_score_2;
  logic              r_goal_1, r_goal_2;

  logic              w_step;
  hit_t              w_hit_1, w_hit_2;
  logic signed [4:0] w_vx, w_vy, w_vx_nxt, w_vy_nxt;
  logic [FW-1:0]     w_fric;
  logic signed [13:0] w_xn, w_yn;
  logic [11:0]       w_x_nxt, w_y_nxt;
  logic              w_mouth, w_goal_1, w_goal_2;

  assign w_step  = tick & ~pause;
  assign w_hit_1 = contact(r_x, r_y, xpos_player_1, ypos_player_1, L_HS);
  assign w_hit_2 = contact(r_x, r_y, xpos_player_2, ypos_player_2, -L_HS);

  always_comb begin
    w_vx     = r_vx;
    w_vy     = r_vy;
    w_fric   = r_fric;
    w_goal_1 = 1'b0;
    w_goal_2 = 1'b0;
    if (w_hit_1.hit) begin
      w_vx   = w_hit_1.vx;
      w_vy   = w_hit_1.vy;
      w_fric = '0;
    end else if (w_hit_2.hit) begin
      w_vx   = w_hit_2.vx;
      w_vy   = w_hit_2.vy;
      w_fric = '0;
    end else if (r_fric == L_FRIC_LAST) begin
      w_fric = '0;
      w_vx   = toward_zero(r_vx);
      w_vy   = toward_zero(r_vy);
    end else begin
      w_fric = r_fric + FW'(1);
    end
    w_xn = $signed({2'b00, r_x}) + 14'(w_vx);
    w_yn = $signed({2'b00, r_y}) + 14'(w_vy);
    if (w_yn < L_Y_LO) begin
      w_y_nxt  = L_Y_LO_P;
      w_vy_nxt = clamp_neg(w_vy);
    end else if (w_yn > L_Y_HI) begin
      w_y_nxt  = L_Y_HI_P;
      w_vy_nxt = clamp_neg(w_vy);
    end else begin
      w_y_nxt  = w_yn[11:0];
      w_vy_nxt = w_vy;
    end
    // Goal mouth is judged on the y already corrected by the y walls.
    w_mouth = (w_y_nxt >= L_GY_LO) && (w_y_nxt <= L_GY_HI);
    if (w_xn <= L_X_LO) begin
      w_x_nxt  = L_X_LO_P;
      w_vx_nxt = clamp_neg(w_vx);
      w_goal_2 = w_mouth;
    end else if (w_xn >= L_X_HI) begin
      w_x_nxt  = L_X_HI_P;
      w_vx_nxt = clamp_neg(w_vx);
      w_goal_1 = w_mouth;
    end else begin
      w_x_nxt  = w_xn[11:0];
      w_vx_nxt = w_vx;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_x       <= L_START_X;
      r_y       <= L_START_Y;
      r_vx      <= 5'sd0;
      r_vy      <= 5'sd0;
      r_fric    <= '0;
      r_hold    <= '0;
      r_score_1 <= 4'd0;
      r_score_2 <= 4'd0;
      r_goal_1  <= 1'b0;
      r_goal_2  <= 1'b0;
    end else begin
      r_goal_1 <= 1'b0;
      r_goal_2 <= 1'b0;
      if (w_step) begin
        case (r_state)
          S_PLAY: begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_fric <= w_fric;
            if (w_goal_1 || w_goal_2) begin
              r_vx     <= 5'sd0;
              r_vy     <= 5'sd0;
              r_hold   <= '0;
              r_goal_1 <= w_goal_1;
              r_goal_2 <= w_goal_2;
              if (w_goal_1 && (r_score_1 != 4'd15)) r_score_1 <= r_score_1 + 4'd1;
              if (w_goal_2 && (r_score_2 != 4'd15)) r_score_2 <= r_score_2 + 4'd1;
            end else begin
              r_vx <= w_vx_nxt;
              r_vy <= w_vy_nxt;
            end
          end
          S_GOAL: begin
            if (r_hold == L_HOLD_LAST) begin
              r_x    <= L_START_X;
              r_y    <= L_START_Y;
              r_vx   <= 5'sd0;
              r_vy   <= 5'sd0;
              r_fric <= '0;
              r_hold <= '0;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
          default: begin
            r_hold <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= S_PLAY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PLAY:  w_state_nxt = (w_step && (w_goal_1 || w_goal_2)) ? S_GOAL : S_PLAY;
      S_GOAL:  w_state_nxt = (w_step && (r_hold == L_HOLD_LAST)) ? S_PLAY : S_GOAL;
      default: w_state_nxt = S_PLAY;
    endcase
  end

  always_comb begin
    in_play = (r_state == S_PLAY);
  end

  assign xpos_ball = r_x;
  assign ypos_ball = r_y;
  assign goal_p1   = r_goal_1;
  assign goal_p2   = r_goal_2;
  assign score_p1  = r_score_1;
  assign score_p2  = r_score_2;

endmodule

// File: tb/tb_puck_physics_ctl.sv
// Bench for puck_physics_ctl: directed scenarios plus random mallet play, all checked
// against an integer reference model of the puck rules.
module tb_puck_physics_ctl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] xpos_player_1 = 12'd2000, ypos_player_1 = 12'd2000;
  logic [11:0] xpos_player_2 = 12'd2000, ypos_player_2 = 12'd2000;
  logic [11:0] xpos_ball, ypos_ball;
  logic        goal_p1, goal_p2, in_play;
  logic [3:0]  score_p1, score_p2;

  always #5 clk_in = ~clk_in;

  puck_physics_ctl dut (
    .clk_in(clk_in), .rst(rst), .tick(tick), .pause(pause),
    .xpos_player_1(xpos_player_1), .ypos_player_1(ypos_player_1),
    .xpos_player_2(xpos_player_2), .ypos_player_2(ypos_player_2),
    .xpos_ball(xpos_ball), .ypos_ball(ypos_ball),
    .goal_p1(goal_p1), .goal_p2(goal_p2),
    .score_p1(score_p1), .score_p2(score_p2), .in_play(in_play)
  );

  localparam int FAR = 2000;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int mx, my, mvx, mvy, mfric, mhold, ms1, ms2;
  bit mplay, mg1, mg2;

  logic [34:0] dut_vec;
  assign dut_vec = {xpos_ball, ypos_ball, score_p1, score_p2, in_play, goal_p1, goal_p2};

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [34:0] exp_vec();
    logic [11:0] ex, ey;
    logic [3:0]  e1, e2;
    ex = 12'(mx); ey = 12'(my); e1 = 4'(ms1); e2 = 4'(ms2);
    return {ex, ey, e1, e2, mplay, mg1, mg2};
  endfunction

  task automatic model_reset();
    mx = 487; my = 362; mvx = 0; mvy = 0; mfric = 0; mhold = 0;
    ms1 = 0; ms2 = 0; mplay = 1'b1; mg1 = 1'b0; mg2 = 1'b0;
  endtask

  task automatic model_step(input int p1x, input int p1y, input int p2x, input int p2y);
    int nvx, nvy, xn, yn, dx, dy, px, py;
    bit hit;
    mg1 = 1'b0; mg2 = 1'b0;
    if (!mplay) begin
      if (mhold == 119) begin
        mx = 487; my = 362; mvx = 0; mvy = 0; mfric = 0; mhold = 0; mplay = 1'b1;
      end else begin
        mhold++;
      end
      return;
    end
    hit = 1'b0; nvx = mvx; nvy = mvy;
    for (int k = 0; k < 2; k++) begin
      px = (k == 0) ? p1x : p2x;
      py = (k == 0) ? p1y : p2y;
      dx = mx - px; dy = my - py;
      if (!hit && (dx * dx + dy * dy <= 900)) begin
        hit = 1'b1;
        if (dx == 0 && dy == 0) begin
          nvx = (k == 0) ? 6 : -6; nvy = 0;
        end else begin
          nvx = (2 * iabs(dx) >= iabs(dy)) ? 6 * sgn(dx) : 0;
          nvy = (2 * iabs(dy) >= iabs(dx)) ? 6 * sgn(dy) : 0;
        end
      end
    end
    if (hit) mfric = 0;
    else begin
      mfric++;
      if (mfric == 8) begin
        mfric = 0; nvx -= sgn(nvx); nvy -= sgn(nvy);
      end
    end
    xn = mx + nvx; yn = my + nvy;
    if (yn - 10 < 32) begin yn = 42; nvy = -nvy; end
    else if (yn + 10 > 735) begin yn = 725; nvy = -nvy; end
    if (xn - 10 <= 32) begin
      xn = 42;
      if (yn >= 300 && yn <= 468) begin mg2 = 1'b1; if (ms2 < 15) ms2++; end
      else nvx = -nvx;
    end else if (xn + 10 >= 991) begin
      xn = 981;
      if (yn >= 300 && yn <= 468) begin mg1 = 1'b1; if (ms1 < 15) ms1++; end
      else nvx = -nvx;
    end
    if (mg1 || mg2) begin nvx = 0; nvy = 0; mhold = 0; mplay = 1'b0; end
    mx = xn; my = yn; mvx = nvx; mvy = nvy;
  endtask

  task automatic apply_reset();
    tick = 1'b0; pause = 1'b0;
    xpos_player_1 = 12'd2000; ypos_player_1 = 12'd2000;
    xpos_player_2 = 12'd2000; ypos_player_2 = 12'd2000;
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic do_tick(input int a, input int b, input int c, input int d, input bit pz);
    xpos_player_1 = 12'(a); ypos_player_1 = 12'(b);
    xpos_player_2 = 12'(c); ypos_player_2 = 12'(d);
    pause = pz; tick = 1'b1;
    @(posedge clk_in);
    #1 tick = 1'b0; pause = 1'b0;
    if (!pz) model_step(a, b, c, d);
    else begin mg1 = 1'b0; mg2 = 1'b0; end
  endtask

  task automatic idle();
    @(posedge clk_in);
    #1 mg1 = 1'b0; mg2 = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({xpos_ball, ypos_ball, score_p1, score_p2, in_play, goal_p1, goal_p2} !== {12'd487, 12'd362, 4'd0, 4'd0, 3'b100}) begin
      n_errors++; $display("FAIL reset_state act=%h exp=%h", dut_vec, {12'd487, 12'd362, 4'd0, 4'd0, 3'b100});
    end
    repeat (20) begin
      do_tick(FAR, FAR, FAR, FAR, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL idle_step act=%h exp=%h", dut_vec, exp_vec()); end
      idle();
    end
    n_checks++;
    if ({xpos_ball, ypos_ball, in_play} !== {12'd487, 12'd362, 1'b1}) begin
      n_errors++; $display("FAIL idle_hold act=%0d,%0d,%b exp=487,362,1", xpos_ball, ypos_ball, in_play);
    end
  endtask

  task automatic test_hit();
    apply_reset();
    do_tick(457, 362, FAR, FAR, 1'b0);
    n_checks++;
    if ({xpos_ball, ypos_ball} !== {12'd493, 12'd362}) begin
      n_errors++; $display("FAIL hit_first act=%0d,%0d exp=493,362", xpos_ball, ypos_ball);
    end
    idle();
    repeat (8) begin
      do_tick(FAR, FAR, FAR, FAR, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL hit_coast act=%h exp=%h", dut_vec, exp_vec()); end
      idle();
    end
    n_checks++;
    if (xpos_ball !== 12'd540) begin n_errors++; $display("FAIL friction_decay act=%0d exp=540", xpos_ball); end
  endtask

  task automatic test_both_hit();
    apply_reset();
    do_tick(457, 362, 517, 362, 1'b0);
    n_checks++;
    if ({xpos_ball, ypos_ball} !== {12'd493, 12'd362}) begin
      n_errors++; $display("FAIL both_hit act=%0d,%0d exp=493,362", xpos_ball, ypos_ball);
    end
    idle();
  endtask

  task automatic test_pause();
    apply_reset();
    do_tick(457, 362, FAR, FAR, 1'b0);
    idle();
    repeat (5) begin
      do_tick(FAR, FAR, 523, 362, 1'b1);
      n_checks++;
      if ({xpos_ball, ypos_ball, in_play} !== {12'd493, 12'd362, 1'b1}) begin
        n_errors++; $display("FAIL pause_hold act=%0d,%0d exp=493,362", xpos_ball, ypos_ball);
      end
      idle();
    end
    do_tick(FAR, FAR, FAR, FAR, 1'b0);
    n_checks++;
    if (xpos_ball !== 12'd499) begin n_errors++; $display("FAIL pause_resume act=%0d exp=499", xpos_ball); end
    idle();
  endtask

  task automatic test_wall();
    int g;
    bit bounced;
    apply_reset();
    g = 0;
    while (my > 150 && g < 100) begin
      do_tick(mx, my + 30, FAR, FAR, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL wall_up act=%h exp=%h", dut_vec, exp_vec()); end
      idle(); g++;
    end
    g = 0; bounced = 1'b0;
    while (!bounced && g < 200) begin
      do_tick(FAR, FAR, mx + 30, my, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL wall_left act=%h exp=%h", dut_vec, exp_vec()); end
      if (mx == 42) bounced = 1'b1;
      else idle();
      g++;
    end
    n_checks++;
    if (!bounced) begin
      n_errors++; $display("FAIL wall_timeout act=%0d exp=42", xpos_ball);
    end else if ({xpos_ball, score_p1, score_p2, goal_p1, goal_p2, in_play} !== {12'd42, 4'd0, 4'd0, 3'b001}) begin
      n_errors++; $display("FAIL wall_bounce act=%0d,%0d,%0d,%b%b exp=42,0,0,00", xpos_ball, score_p1, score_p2, goal_p1, goal_p2);
    end
    idle();
    do_tick(FAR, FAR, FAR, FAR, 1'b0);
    n_checks++;
    if (xpos_ball !== 12'd48) begin n_errors++; $display("FAIL wall_rebound act=%0d exp=48", xpos_ball); end
    idle();
  endtask

  task automatic test_goal();
    int g;
    apply_reset();
    g = 0;
    while (!mg2 && g < 200) begin
      idle();
      do_tick(FAR, FAR, mx + 30, 362, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL goal_push act=%h exp=%h", dut_vec, exp_vec()); end
      g++;
    end
    n_checks++;
    if ({goal_p2, score_p2, xpos_ball, ypos_ball, in_play} !== {1'b1, 4'd1, 12'd42, 12'd362, 1'b0}) begin
      n_errors++; $display("FAIL goal_left act=%b,%0d,%0d,%0d,%b exp=1,1,42,362,0", goal_p2, score_p2, xpos_ball, ypos_ball, in_play);
    end
    idle();
    n_checks++;
    if (goal_p2 !== 1'b0) begin n_errors++; $display("FAIL goal_pulse_width act=%b exp=0", goal_p2); end
    for (int i = 0; i < 120; i++) begin
      if (i == 60) begin
        repeat (10) begin do_tick(FAR, FAR, FAR, FAR, 1'b1); idle(); end
      end
      do_tick(FAR, FAR, FAR, FAR, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL goal_hold act=%h exp=%h", dut_vec, exp_vec()); end
      if (i == 118) begin
        n_checks++;
        if (in_play !== 1'b0) begin n_errors++; $display("FAIL hold_len act=%b exp=0", in_play); end
      end
      idle();
    end
    n_checks++;
    if ({xpos_ball, ypos_ball, in_play} !== {12'd487, 12'd362, 1'b1}) begin
      n_errors++; $display("FAIL faceoff act=%0d,%0d,%b exp=487,362,1", xpos_ball, ypos_ball, in_play);
    end
    g = 0;
    while (!mg2 && g < 200) begin
      idle();
      do_tick(FAR, FAR, mx + 30, 362, 1'b0);
      g++;
    end
    repeat (5) begin idle(); do_tick(FAR, FAR, FAR, FAR, 1'b0); end
    rst = 1'b1;
    #2;
    n_checks++;
    if ({xpos_ball, ypos_ball, score_p2, in_play} !== {12'd487, 12'd362, 4'd0, 1'b1}) begin
      n_errors++; $display("FAIL reset_mid_goal act=%0d,%0d,%0d,%b exp=487,362,0,1", xpos_ball, ypos_ball, score_p2, in_play);
    end
    apply_reset();
  endtask

  task automatic test_saturation();
    int goals, g;
    apply_reset();
    goals = 0; g = 0;
    while (goals < 16 && g < 5000) begin
      do_tick(mx - 30, 362, FAR, FAR, 1'b0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL sat_step act=%h exp=%h", dut_vec, exp_vec()); end
      if (mg1) begin
        goals++;
        if (goals == 16) begin
          n_checks++;
          if ({goal_p1, score_p1} !== {1'b1, 4'd15}) begin
            n_errors++; $display("FAIL score_saturate act=%b,%0d exp=1,15", goal_p1, score_p1);
          end
        end
      end
      idle(); g++;
    end
    n_checks++;
    if (goals != 16) begin n_errors++; $display("FAIL sat_timeout act=%0d exp=16", goals); end
  endtask

  task automatic test_random();
    int a, b, c, d;
    bit pz;
    apply_reset();
    repeat (1500) begin
      a = FAR; b = FAR; c = FAR; d = FAR;
      if ($urandom_range(0, 1) == 1) begin
        a = mx + int'($urandom_range(0, 80)) - 40; b = my + int'($urandom_range(0, 80)) - 40;
      end
      if ($urandom_range(0, 1) == 1) begin
        c = mx + int'($urandom_range(0, 80)) - 40; d = my + int'($urandom_range(0, 80)) - 40;
      end
      pz = ($urandom_range(0, 15) == 0);
      do_tick(a, b, c, d, pz);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_errors++; $display("FAIL random_step act=%h exp=%h", dut_vec, exp_vec()); end
      idle();
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_both_hit();
    test_pause();
    test_wall();
    test_goal();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
